// File: rtl/ram_access_master.sv
// Initiator for a single-port word RAM: byte/half/word loads and stores,
// big-endian lanes, read-modify-write for sub-word stores.
module ram_access_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        signed_q;
    logic [15:0] wdata_q;
    logic        ram_read_q;
    logic        ram_write_q;
    logic        bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Strobes are masked by reset so no RAM write can commit in a reset cycle.
    assign ram_read  = ram_read_q & ~reset;
    assign ram_write = ram_write_q & ~reset;
    assign req_ready = (state == IDLE);

    assign bad = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (|req_addr[1:0]));

    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
        load_val  = ram_rdata;
        merge_val = ram_rdata;
        unique case (off_q)
            2'd0: byte_sel = ram_rdata[31:24];
            2'd1: byte_sel = ram_rdata[23:16];
            2'd2: byte_sel = ram_rdata[15:8];
            2'd3: byte_sel = ram_rdata[7:0];
        endcase
        unique case (1'b1)
            (size_q == 2'b00): begin
                load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
                unique case (off_q)
                    2'd0: merge_val[31:24] = wdata_q[7:0];
                    2'd1: merge_val[23:16] = wdata_q[7:0];
                    2'd2: merge_val[15:8]  = wdata_q[7:0];
                    2'd3: merge_val[7:0]   = wdata_q[7:0];
                endcase
            end
            (size_q == 2'b01): begin
                load_val = {{16{signed_q & half_sel[15]}}, half_sel};
                if (off_q[1]) merge_val[15:0]  = wdata_q;
                else          merge_val[31:16] = wdata_q;
            end
            default: begin
                load_val  = ram_rdata;
                merge_val = ram_rdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            wdata_q     <= 16'h0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= 32'h0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= 32'h0;
        end else begin
            rsp_valid   <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q    <= req_addr[1:0];
                        size_q   <= req_size;
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata[15:0];
                        if (bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_write && req_size == 2'b10) begin
                            state       <= WR;
                            ram_write_q <= 1'b1;
                            ram_address <= req_addr[ADDR_W+1:2];
                            ram_wdata   <= req_wdata;
                        end else begin
                            state       <= RD;
                            ram_read_q  <= 1'b1;
                            ram_address <= req_addr[ADDR_W+1:2];
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (write_q) begin
                        state       <= WR;
                        ram_write_q <= 1'b1;
                        ram_wdata   <= merge_val;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_val;
                    end
                end
                WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a behavioural
// one-cycle-latency word RAM.
module tb_ram_access_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_read;
    logic        ram_write;
    logic [4:0]  ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] mem [32] = '{default: 32'h0};

    int n_cmp = 0;
    int n_bad = 0;

    ram_access_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_address(ram_address), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_wdata;
        if (ram_read) ram_rdata <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz,
                           input logic sg, input logic [6:0] a,
                           input logic [31:0] wd);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // One transaction from IDLE; returns to IDLE before finishing.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [6:0] a,
                        input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_nrd, input int exp_nwr,
                        input logic [31:0] exp_ww);
        int lat = 0;
        int nrd = 0;
        int nwr = 0;
        logic [31:0] rd = 32'h0;
        logic [31:0] ww = 32'h0;
        logic [4:0] wa = 5'h0;
        logic er = 1'b0;
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        set_req(w, sz, sg, a, wd);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        set_req(~w, 2'b10, ~sg, a ^ 7'h6c, ~wd);
        for (int k = 1; k <= 8; k++) begin
            if (ram_read) nrd++;
            if (ram_write) begin
                nwr++;
                ww = ram_wdata;
                wa = ram_address;
            end
            if (rsp_valid) begin
                lat = k;
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
        check({tag, "_nrd"}, nrd, exp_nrd);
        check({tag, "_nwr"}, nwr, exp_nwr);
        if (exp_nwr > 0) begin
            check({tag, "_wword"}, ww, exp_ww);
            check({tag, "_waddr"}, {27'h0, wa}, {27'h0, a[6:2]});
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] b2b_exp [3];
    int acc;
    int rsp;
    int last_acc;
    int seen_wr;
    int seen_rsp;
    logic take;

    initial begin
        reset = 1'b1;
        set_req(1'b1, 2'b10, 1'b0, 7'h00, 32'hffffffff);
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_ram_read", {31'h0, ram_read}, 32'h0);
        check("rst_ram_write", {31'h0, ram_write}, 32'h0);
        check("rst_ram_addr", {27'h0, ram_address}, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        reset = 1'b0;
        req_valid = 1'b0;
        seen_wr = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ram_write || rsp_valid) seen_wr++;
        end
        check("rst_no_accept", seen_wr, 0);

        xact("sw_10", 1, 2'b10, 0, 7'h10, 32'hdeadbeef, 2, 32'h0, 0, 0, 1, 32'hdeadbeef);
        xact("lw_10", 0, 2'b10, 0, 7'h10, 32'h0, 3, 32'hdeadbeef, 0, 1, 0, 32'h0);
        xact("lb_11", 0, 2'b00, 1, 7'h11, 32'h0, 3, 32'hffffffad, 0, 1, 0, 32'h0);
        xact("lbu_11", 0, 2'b00, 0, 7'h11, 32'h0, 3, 32'h000000ad, 0, 1, 0, 32'h0);
        xact("lb_13", 0, 2'b00, 1, 7'h13, 32'h0, 3, 32'hffffffef, 0, 1, 0, 32'h0);
        xact("lbu_10", 0, 2'b00, 0, 7'h10, 32'h0, 3, 32'h000000de, 0, 1, 0, 32'h0);
        xact("lh_10", 0, 2'b01, 1, 7'h10, 32'h0, 3, 32'hffffdead, 0, 1, 0, 32'h0);
        xact("lhu_12", 0, 2'b01, 0, 7'h12, 32'h0, 3, 32'h0000beef, 0, 1, 0, 32'h0);
        xact("sh_12", 1, 2'b01, 0, 7'h12, 32'hffff1234, 4, 32'h0, 0, 1, 1, 32'hdead1234);
        xact("lw_10b", 0, 2'b10, 0, 7'h10, 32'h0, 3, 32'hdead1234, 0, 1, 0, 32'h0);
        xact("sb_1f", 1, 2'b00, 0, 7'h1f, 32'h123456a5, 4, 32'h0, 0, 1, 1, 32'h000000a5);
        xact("sb_1c", 1, 2'b00, 0, 7'h1c, 32'h00000077, 4, 32'h0, 0, 1, 1, 32'h770000a5);
        xact("sw_7c", 1, 2'b10, 0, 7'h7c, 32'h81020304, 2, 32'h0, 0, 0, 1, 32'h81020304);
        xact("lb_7c", 0, 2'b00, 1, 7'h7c, 32'h0, 3, 32'hffffff81, 0, 1, 0, 32'h0);
        xact("lhu_7e", 0, 2'b01, 1, 7'h7e, 32'h0, 3, 32'h00000304, 0, 1, 0, 32'h0);
        xact("err_lw13", 0, 2'b10, 0, 7'h13, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);
        xact("err_sh11", 1, 2'b01, 0, 7'h11, 32'h5555, 1, 32'h0, 1, 0, 0, 32'h0);
        xact("err_sz3", 0, 2'b11, 0, 7'h10, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0);

        // Reset while the byte store sits in CAP.
        set_req(1, 2'b00, 0, 7'h10, 32'h00000055);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen_wr = 0;
        seen_rsp = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rcap_ready", {31'h0, req_ready}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            if (ram_write) seen_wr++;
            if (rsp_valid) seen_rsp++;
            @(posedge clk); #1;
        end
        check("rcap_nwr", seen_wr, 0);
        check("rcap_nrsp", seen_rsp, 0);
        xact("rcap_lw", 0, 2'b10, 0, 7'h10, 32'h0, 3, 32'hdead1234, 0, 1, 0, 32'h0);

        // Reset landing on the WR cycle itself must mask the strobe.
        set_req(1, 2'b00, 0, 7'h10, 32'h00000055);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rwr_pre", {31'h0, ram_write}, 32'h1);
        reset = 1'b1;
        #1;
        check("rwr_mask", {31'h0, ram_write}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rwr_nrsp", {31'h0, rsp_valid}, 32'h0);
        check("rwr_ready", {31'h0, req_ready}, 32'h1);
        xact("rwr_lw", 0, 2'b10, 0, 7'h10, 32'h0, 3, 32'hdead1234, 0, 1, 0, 32'h0);

        // Three loads with req_valid held high.
        b2b_exp[0] = 32'hdead1234;
        b2b_exp[1] = 32'h000000ad;
        b2b_exp[2] = 32'h00001234;
        set_req(0, 2'b10, 0, 7'h10, 32'h0);
        req_valid = 1'b1;
        acc = 0;
        rsp = 0;
        last_acc = 0;
        for (int c = 0; c < 40 && rsp < 3; c++) begin
            if (rsp_valid) begin
                check("b2b_rdata", rsp_rdata, b2b_exp[rsp]);
                rsp++;
            end
            take = req_valid && req_ready;
            @(posedge clk); #1;
            if (take) begin
                if (acc > 0) check("b2b_gap", c - last_acc, 4);
                last_acc = c;
                acc++;
                if (acc == 1) set_req(0, 2'b00, 0, 7'h11, 32'h0);
                else if (acc == 2) set_req(0, 2'b01, 0, 7'h12, 32'h0);
                else req_valid = 1'b0;
            end
        end
        check("b2b_acc", acc, 3);
        check("b2b_rsp", rsp, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
